// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit.
// Op codes, FSM states and the op-class helpers.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return op[2] == 1'b0;
  endfunction

  function automatic logic is_move(input logic [2:0] op);
    return op[2:1] == 2'b10;
  endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of the shared datapath: shift-add for
// multiply, restoring shift-subtract for divide.
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               div,
  input  logic               bin,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
         + (bin ? {1'b0, opnd} : '0);
    shl  = {acc[2*WIDTH-1:WIDTH], bin};
    ge   = shl >= {1'b0, opnd};
    // remainder after subtract always fits WIDTH bits
    diff = shl[WIDTH-1:0] - opnd;
    if (div)
      acc_nxt = {ge ? diff : shl[WIDTH-1:0],
                 acc[WIDTH-2:0], ge};
    else
      acc_nxt = {sum, acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning HI/LO.
// 33-cycle MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);

  md_state_e state, state_n;

  logic [CW-1:0]      cnt;
  logic [CW-1:0]      idx;
  logic [WIDTH-1:0]   src;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;

  logic               go;
  logic               mt;
  logic               sgn;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] p_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  always_comb begin
    go    = (state == IDLE) && md_start && is_arith(md_op);
    mt    = (state == IDLE) && md_start && is_move(md_op);
    sgn   = ~md_op[0];
    sa    = sgn & a[WIDTH-1];
    sb    = sgn & b[WIDTH-1];
    a_mag = sa ? -a : a;
    b_mag = sb ? -b : b;
    // multiplier consumed LSB first, dividend MSB first
    idx   = is_div ? CLAST - cnt : cnt;
    p_fix = neg_q ? -acc : acc;
    q_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix = neg_r ? -acc[2*WIDTH-1:WIDTH]
                  : acc[2*WIDTH-1:WIDTH];
  end

  md_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .opnd    (opnd),
    .div     (is_div),
    .bin     (src[idx]),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (go) state_n = CALC;
      CALC:    if (cnt == CLAST) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      src    <= '0;
      opnd   <= '0;
      acc    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      busy <= state_n != IDLE;
      done <= state == FIX;
      unique case (state)
        IDLE: begin
          if (go) begin
            src    <= a_mag;
            opnd   <= b_mag;
            acc    <= '0;
            cnt    <= '0;
            is_div <= md_op[1];
            // divide by zero keeps quotient all ones
            neg_q  <= (sa ^ sb)
                    & ~(md_op[1] && b == '0);
            neg_r  <= sa & md_op[1];
          end else if (mt) begin
            if (md_op[0]) lo <= a;
            else          hi <= a;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= p_fix[2*WIDTH-1:WIDTH];
            lo <= p_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: directed corner cases
// plus random ops against an arithmetic reference model.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_start),
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          bcnt  = 0;
  logic [63:0] sb_q[$];
  logic [63:0] exp_v;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] ref_md(
      input logic [2:0] op,
      input logic [31:0] x,
      input logic [31:0] y);
    longint sx;
    longint sy;
    longint r;
    logic [63:0] ux;
    logic [63:0] uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (op == MD_MULT) begin
      r = sx * sy;
      return 64'(r);
    end
    if (op == MD_MULTU) return ux * uy;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (op == MD_DIV) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
        return {32'd0, 32'h8000_0000};
      return {32'(sx % sy), 32'(sx / sy)};
    end
    return {32'(ux % uy), 32'(ux / uy)};
  endfunction

  // monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (rst) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          exp_v = sb_q.pop_front();
          chk("result", {hi, lo}, exp_v);
          chk("busy_cycles", 64'(bcnt), 64'd33);
        end
        bcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op,
                      input logic [31:0] x,
                      input logic [31:0] y);
    md_start = 1'b1;
    md_op    = op;
    a        = x;
    b        = y;
    tick();
    md_start = 1'b0;
    md_op    = 3'($urandom);
    a        = $urandom;
    b        = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) chk("timeout", 64'd1, 64'd0);
  endtask

  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [63:0] e);
    sb_q.push_back(e);
    send(op, x, y);
    wait_idle();
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic run_mt(input logic [2:0] op,
                        input logic [31:0] x);
    send(op, x, $urandom);
    if (op == MD_MTHI) m_hi = x;
    else if (op == MD_MTLO) m_lo = x;
    chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
    chk("mt_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    rst      = 1'b1;
    md_start = 1'b0;
    md_op    = 3'd0;
    a        = '0;
    b        = '0;
    #12;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_mt(MD_MTLO, 32'hDEAD_BEEF);
    run_mt(MD_MTHI, 32'hCAFE_F00D);

    // asynchronous reset between edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    chk("async_rst_bd", {62'd0, busy, done}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5,
           {32'hFFFF_FFFF, 32'hFFFF_FFF1});
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           {32'hFFFF_FFFE, 32'h0000_0001});
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2,
           {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           {32'd0, 32'h8000_0000});
    run_op(MD_DIVU, 32'd5, 32'd0,
           {32'd5, 32'hFFFF_FFFF});
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd0,
           {32'hFFFF_FFF9, 32'hFFFF_FFFF});

    // MTHI while busy must be dropped
    sb_q.push_back({32'd2, 32'd14});
    send(MD_DIVU, 32'd100, 32'd7);
    repeat (5) tick();
    send(MD_MTHI, 32'h1234, 32'd0);
    wait_idle();
    m_hi = 32'd2;
    m_lo = 32'd14;
    tick();
    chk("collide_hilo", {hi, lo}, {m_hi, m_lo});

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = $urandom;
      if ($urandom_range(0, 7) == 0) y = '0;
      if ($urandom_range(0, 7) == 0) begin
        x = 32'h8000_0000;
        y = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 9));
      if (is_arith(op)) begin
        run_op(op, x, y, ref_md(op, x, y));
      end else begin
        run_mt(op, x);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    // abort a MULT at iteration 10
    send(MD_MULT, 32'd7, 32'd9);
    repeat (10) tick();
    #3 rst = 1'b1;
    #1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_bd", {62'd0, busy, done}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) tick();
    chk("abort_idle", {31'd0, busy, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);

    run_op(MD_MULTU, 32'd6, 32'd7, {32'd0, 32'd42});
    tick();
    chk("queue_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit that owns the HI/LO register pair for the execute stage. It runs beside the single-cycle ALU: it takes the same register-file operands `a`/`b`, runs MULT/MULTU/DIV/DIVU over 33 cycles, and handles MTHI/MTLO. It exposes HI/LO for MFHI/MFLO forwarding. The pipeline controller stalls on `busy` and consumes `done`.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. Only 32 is verified.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `md_start`  in  1: request strobe. Sampled on the rising edge together with `md_op`, `a` and `b`.
- `md_op`  in  3: operation code.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- `a`  in  WIDTH: rs operand, or the dividend.
- `b`  in  WIDTH: rt operand, or the divisor.
- `busy`  out  1: high while an arithmetic operation is in flight.
- `done`  out  1: one-cycle pulse when HI/LO have just been updated by MULT/MULTU/DIV/DIVU.
- `hi`  out  WIDTH: current HI register, driven directly from the flop.
- `lo`  out  WIDTH: current LO register, driven directly from the flop.

## Operation
States:
- IDLE: waiting for a request.
- CALC: 32 iterations.
- FIX: sign correction and commit.

Transitions:
- IDLE with `md_start` and `md_op` in 000..011:
  - latch |a| and |b| (raw values for unsigned ops);
  - latch the result-sign and remainder-sign flags;
  - clear the 64-bit accumulator and the 5-bit counter;
  - go to CALC.
- IDLE with `md_start` and `md_op` = 100 or 101: write `a` into HI or LO on that edge. Stay in IDLE; no `busy`, no `done`.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle.
- CALC exit: after 32 iterations (counter = 31 on the last one), go to FIX.
- FIX: apply two's-complement negation per the sign flags, write HI/LO, set `done`, go to IDLE.

Results:
- MULT/MULTU: the full 64-bit product; HI = [63:32], LO = [31:0].
- DIV/DIVU: LO = quotient, HI = remainder.
- Signed divide truncates toward zero. The remainder takes the dividend's sign.

Boundary cases:
- Divide by zero (b = 0, signed or unsigned): LO = all ones, HI = `a` unchanged. The op still takes the full latency.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- |0x80000000|: treated as unsigned 0x80000000 internally. The magnitude path is WIDTH bits unsigned.
- `md_start` while `busy`: ignored entirely, including MTHI/MTLO. The in-flight op is not disturbed.
- `md_start` on the FIX cycle: ignored, because `busy` is still high.
- Reset mid-operation: abandons the op. State returns to IDLE and HI/LO are cleared.

## Timing
- Reset values: state IDLE; `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0.
- Edge numbering: the request is accepted on edge E0.
  - `busy` = 1 from after E0.
  - CALC occupies edges E1..E32.
  - FIX commits on edge E33.
  - After E33: `hi`/`lo` show the new values, `done` = 1 for exactly one cycle, `busy` = 0.
- Back-to-back: a new request may be sampled on E34, the first edge after `busy` falls. That is a 34-cycle issue interval.
- MTHI/MTLO: the new value is visible on `hi`/`lo` the cycle after the accepting edge.
- `done` and `busy` are registered outputs. Neither has a combinational path from any input.

## Structure
- Package `md_pkg`:
  - the `md_op` encodings as localparams (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`);
  - the state encoding (IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2).
- The top module holds the FSM, counter, sign flags, and the HI/LO registers.
- One sub-module, `md_step`: combinational single-iteration datapath. It takes the accumulator, multiplicand/divisor and a mode bit, and returns the next accumulator. One instance is used for both mult and div.

## Test plan
- Reset: assert `rst` asynchronously between edges → `hi` = `lo` = 0, `busy` = `done` = 0 at once, without waiting for a clock edge.
- MULT, a = 0xFFFFFFFD (-3), b = 5 → on the cycle after E33: `done` = 1, HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; `busy` high for exactly 33 cycles.
- MULTU, a = b = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- Divide cases:
  - DIV, a = 0xFFFFFFF9 (-7), b = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIV, a = 0x80000000, b = 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU, a = 5, b = 0 → LO = 0xFFFFFFFF, HI = 5, `done` at the normal latency.
- Collision and abort:
  - pulse `md_start` with MTHI a = 0x1234 while `busy` → HI unaffected and the DIVU result unchanged;
  - then assert `rst` at iteration 10 of a new MULT → IDLE, HI/LO = 0, no `done` pulse.
